// File: rtl/seg_scan_display.sv
// Latches a binary value, converts it to BCD with a serial double-dabble engine
// and time-multiplexes it onto DIGITS seven-segment digits (macro: LEADING_ZERO_BLANK_EN).
module seg_scan_display #(
  parameter int DIGITS   = 4,
  parameter int BIN_W    = 14,
  parameter int SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [BIN_W-1:0]  number_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              ovf_o,
  output logic [DIGITS-1:0] dig_sel_o,
  output logic [6:0]        seg_o
);
  localparam int BCD_W = 4*DIGITS + 4;
  localparam int DSP_W = 4*DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int PS_W  = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [6:0] SEG_DASH = 7'b0000001;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, COMMIT = 2'd2} state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int k = 0; k < DIGITS + 1; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) begin
        res[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end else begin
        res[4*k +: 4] = bcd[4*k +: 4];
      end
    end
    return res;
  endfunction

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d, adj_s;
  logic                trunc_q, trunc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DSP_W-1:0]    disp_q, disp_d;
  logic                busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic [PS_W-1:0]     ps_q, ps_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIGITS-1:0]   dig_q, dig_d, blank_s;
  logic [6:0]          seg_q, seg_d;
  logic [3:0]          nib_s;

  // Conversion FSM: capture, BIN_W dabble iterations, then commit to the display.
  // trunc catches bits shifted out of the top nibble so huge inputs still flag overflow.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    trunc_d = trunc_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    adj_s   = dabble_adjust(bcd_q);
    case (state_q)
      IDLE: begin
        if (load_i) begin
          bin_d   = number_i;
          bcd_d   = {BCD_W{1'b0}};
          trunc_d = 1'b0;
          cnt_d   = CNT_W'(BIN_W);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        bcd_d   = {adj_s[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d   = {bin_q[BIN_W-2:0], 1'b0};
        trunc_d = trunc_q | adj_s[BCD_W-1];
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = COMMIT;
        end else begin
          state_d = SHIFT;
        end
      end
      COMMIT: begin
        disp_d  = bcd_q[DSP_W-1:0];
        ovf_d   = trunc_q | (|bcd_q[BCD_W-1:DSP_W]);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Scan prescaler and digit mux; a commit is picked up at the next digit update.
  always_comb begin
    nib_s = disp_q[{idx_q, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    begin : lead_blank
      logic lead_s;
      lead_s  = 1'b1;
      blank_s = {DIGITS{1'b0}};
      for (int i = DIGITS - 1; i >= 0; i--) begin
        lead_s     = lead_s & (disp_q[4*i +: 4] == 4'd0);
        blank_s[i] = lead_s & (i != 0);
      end
    end
`else
    blank_s = {DIGITS{1'b0}};
`endif
    ps_d  = ps_q;
    idx_d = idx_q;
    dig_d = dig_q;
    seg_d = seg_q;
    if (ps_q == PS_W'(SCAN_DIV - 1)) begin
      ps_d = {PS_W{1'b0}};
      if (idx_q == IDX_W'(DIGITS - 1)) begin
        idx_d = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
      dig_d = DIGITS'(1'b1) << idx_q;
      if (ovf_q) begin
        seg_d = SEG_DASH;
      end else if (blank_s[idx_q]) begin
        seg_d = 7'b0000000;
      end else begin
        seg_d = seg_decode(nib_s);
      end
    end else begin
      ps_d = ps_q + PS_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= {BIN_W{1'b0}};
      bcd_q   <= {BCD_W{1'b0}};
      trunc_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      disp_q  <= {DSP_W{1'b0}};
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ps_q    <= {PS_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      dig_q   <= {DIGITS{1'b0}};
      seg_q   <= 7'b0000000;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      trunc_q <= trunc_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ps_q    <= ps_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      seg_q   <= seg_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign ovf_o     = ovf_q;
  assign dig_sel_o = dig_q;
  assign seg_o     = seg_q;
endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: loads push expected results, a
// negedge monitor checks done/ovf/busy timing and every scanned digit.
module tb_seg_scan_display;
  localparam int DIGITS   = 4;
  localparam int BIN_W    = 14;
  localparam int SCAN_DIV = 4;
  localparam int LAT      = BIN_W + 2;

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001, S4 = 7'b0110011, S7 = 7'b1110000;
  localparam logic [6:0] S9 = 7'b1111011, DASH = 7'b0000001;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'b0000000;
`else
  localparam logic [6:0] LZ = 7'b1111110;
`endif
  localparam logic [3:0][6:0] V0    = {LZ, LZ, LZ, S0};
  localparam logic [3:0][6:0] V7    = {LZ, LZ, LZ, S7};
  localparam logic [3:0][6:0] V42   = {LZ, LZ, S4, S2};
  localparam logic [3:0][6:0] V1234 = {S1, S2, S3, S4};
  localparam logic [3:0][6:0] V9999 = {S9, S9, S9, S9};
  localparam logic [3:0][6:0] VOVF  = {DASH, DASH, DASH, DASH};

  typedef struct packed {
    logic [31:0]     due;
    logic            ovf;
    logic [3:0][6:0] segs;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              load_i = 1'b0;
  logic [BIN_W-1:0]  number_i = '0;
  logic              busy_o, done_o, ovf_o;
  logic [DIGITS-1:0] dig_sel_o;
  logic [6:0]        seg_o;

  exp_t            exp_q[$];
  logic [3:0][6:0] cur_segs;
  logic            cur_ovf;
  int              n_checks = 0;
  int              n_fail = 0;
  int              cyc = 0;

  seg_scan_display #(.DIGITS(DIGITS), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .load_i(load_i), .number_i(number_i),
    .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o),
    .dig_sel_o(dig_sel_o), .seg_o(seg_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: scan cadence and digit content, busy length, done timing and overflow.
  always @(negedge clk) begin : mon
    exp_t        e;
    logic        upd;
    logic [3:0]  sel_exp;
    logic [3:0]  prev_sel;
    int          since, exp_idx, busy_cnt;
    if (!rst_n) begin
      prev_sel = 4'b0000;
      since    = 0;
      exp_idx  = 0;
      busy_cnt = 0;
    end else begin
      since++;
      upd = (dig_sel_o != prev_sel);
      if (upd || since == SCAN_DIV) begin
        check("scan_period", since, SCAN_DIV);
        check("scan_update", {31'd0, upd}, 32'd1);
        if (upd) begin
          sel_exp = 4'b0001 << exp_idx;
          check("dig_sel", {28'd0, dig_sel_o}, {28'd0, sel_exp});
          check("seg", {25'd0, seg_o}, {25'd0, cur_segs[exp_idx]});
          exp_idx  = (exp_idx + 1) % DIGITS;
          prev_sel = dig_sel_o;
        end
        since = 0;
      end
      if (busy_o) begin
        busy_cnt++;
      end else if (busy_cnt != 0) begin
        check("busy_len", busy_cnt, BIN_W + 1);
        busy_cnt = 0;
      end
      if (done_o) begin
        if (exp_q.size() == 0) begin
          check("done_spurious", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", cyc, e.due);
          check("ovf_on_done", {31'd0, ovf_o}, {31'd0, e.ovf});
          cur_segs = e.segs;
          cur_ovf  = e.ovf;
        end
      end
      if (upd) check("ovf_hold", {31'd0, ovf_o}, {31'd0, cur_ovf});
    end
  end

  // Asynchronous reset must clear every output without waiting for a clock.
  always @(negedge rst_n) begin
    #1;
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_ovf", {31'd0, ovf_o}, 32'd0);
    check("rst_dig_sel", {28'd0, dig_sel_o}, 32'd0);
    check("rst_seg", {25'd0, seg_o}, 32'd0);
  end

  task automatic do_load(input logic [BIN_W-1:0] v, input logic ovf,
                         input logic [3:0][6:0] segs, input bit expect_done);
    exp_t e;
    @(negedge clk);
    number_i = v;
    load_i   = 1'b1;
    if (expect_done) begin
      e.due  = cyc + LAT;
      e.ovf  = ovf;
      e.segs = segs;
      exp_q.push_back(e);
    end
    @(negedge clk);
    load_i = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    #2;
    rst_n  = 1'b0;
    load_i = 1'b0;
    exp_q.delete();
    cur_segs = V0;
    cur_ovf  = 1'b0;
    repeat (hold) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    cur_segs = V0;
    cur_ovf  = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);

    do_load(14'd1234, 1'b0, V1234, 1'b1);
    repeat (40) @(negedge clk);
    do_load(14'd10000, 1'b1, VOVF, 1'b1);
    repeat (40) @(negedge clk);
    do_load(14'd9999, 1'b0, V9999, 1'b1);
    repeat (40) @(negedge clk);

    do_load(14'd42, 1'b0, V42, 1'b1);
    repeat (1) @(negedge clk);
    do_load(14'd7777, 1'b0, V9999, 1'b0);
    repeat (40) @(negedge clk);

    do_load(14'd7, 1'b0, V7, 1'b1);
    repeat (40) @(negedge clk);
    do_load(14'd0, 1'b0, V0, 1'b1);
    repeat (40) @(negedge clk);

    do_load(14'd1234, 1'b0, V1234, 1'b1);
    repeat (40) @(negedge clk);
    do_load(14'd5678, 1'b0, V0, 1'b0);
    repeat (5) @(negedge clk);
    do_reset(3);
    repeat (40) @(negedge clk);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
